// File: rtl/wb_skid_pipe_regs.sv
// M5->WB elastic pipeline buffer: DEPTH-entry circular FIFO with valid/ready
// handshake, synchronous flush and asynchronous active-high reset.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 4
`endif

module wb_skid_pipe_regs #(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WITDH = `ROB_ENTRY_WITDH,
    parameter int DEPTH           = 2,
    parameter int CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
    input  logic [WORD_SIZE-1:0]       in_pc,
    input  logic [WORD_SIZE-1:0]       in_result,
    input  logic [ROB_ENTRY_WITDH-1:0] in_rob_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_TYPE_SZ-1:0]   out_instruction_type,
    output logic [WORD_SIZE-1:0]       out_pc,
    output logic [WORD_SIZE-1:0]       out_result,
    output logic [ROB_ENTRY_WITDH-1:0] out_rob_id,
    output logic [CNT_W-1:0]           count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0]   instruction_type;
        logic [WORD_SIZE-1:0]       pc;
        logic [WORD_SIZE-1:0]       result;
        logic [ROB_ENTRY_WITDH-1:0] rob_id;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    entry_t             head;

    // Handshake flags depend only on registered occupancy, so a full buffer
    // never accepts even when the head is being consumed in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign head                 = mem_q[rd_ptr_q];
    assign out_instruction_type = head.instruction_type;
    assign out_pc               = head.pc;
    assign out_result           = head.result;
    assign out_rob_id           = head.rob_id;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instruction_type: in_instruction_type,
                                    pc:               in_pc,
                                    result:           in_result,
                                    rob_id:           in_rob_id};
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_wb_skid_pipe_regs.sv
// Self-checking bench for wb_skid_pipe_regs: queue-based reference model
// checked every cycle plus directed literal expectations (DEPTH=2 and DEPTH=3).
`timescale 1ns/1ps
module tb_wb_skid_pipe_regs;

    typedef struct packed {
        logic [2:0]  it;
        logic [31:0] pc;
        logic [31:0] res;
        logic [3:0]  rob;
    } ent_t;

    int checks = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        flush = 0, in_valid = 0, out_ready = 0;
    logic [2:0]  in_it = 0;
    logic [31:0] in_pc = 0, in_res = 0;
    logic [3:0]  in_rob = 0;
    logic        in_ready, out_valid;
    logic [2:0]  out_it;
    logic [31:0] out_pc, out_res;
    logic [3:0]  out_rob;
    logic [1:0]  count;

    // DEPTH=3 instance
    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [2:0]  b_in_it = 0;
    logic [31:0] b_in_pc = 0, b_in_res = 0;
    logic [3:0]  b_in_rob = 0;
    logic        b_in_ready, b_out_valid;
    logic [2:0]  b_out_it;
    logic [31:0] b_out_pc, b_out_res;
    logic [3:0]  b_out_rob;
    logic [1:0]  b_count;

    wb_skid_pipe_regs #(.WORD_SIZE(32), .INSTR_TYPE_SZ(3), .ROB_ENTRY_WITDH(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction_type(in_it), .in_pc(in_pc), .in_result(in_res), .in_rob_id(in_rob),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction_type(out_it), .out_pc(out_pc), .out_result(out_res), .out_rob_id(out_rob),
        .count(count)
    );

    wb_skid_pipe_regs #(.WORD_SIZE(32), .INSTR_TYPE_SZ(3), .ROB_ENTRY_WITDH(4), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instruction_type(b_in_it), .in_pc(b_in_pc), .in_result(b_in_res), .in_rob_id(b_in_rob),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_instruction_type(b_out_it), .out_pc(b_out_pc), .out_result(b_out_res), .out_rob_id(b_out_rob),
        .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of capacity DEPTH; full rejects pushes
    // regardless of a same-cycle pop, flush empties it.
    ent_t mq[$];
    ent_t bq[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            bit full, empty;
            full  = (mq.size() == 2);
            empty = (mq.size() == 0);
            if (out_ready && !empty) void'(mq.pop_front());
            if (in_valid && !full) mq.push_back('{in_it, in_pc, in_res, in_rob});
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bq.delete();
        end else if (b_flush) begin
            bq.delete();
        end else begin
            bit full, empty;
            full  = (bq.size() == 3);
            empty = (bq.size() == 0);
            if (b_out_ready && !empty) void'(bq.pop_front());
            if (b_in_valid && !full) bq.push_back('{b_in_it, b_in_pc, b_in_res, b_in_rob});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_in_ready", 32'(in_ready), 32'(mq.size() != 2));
        if (mq.size() != 0) begin
            chk("m_out_pc", out_pc, mq[0].pc);
            chk("m_out_res", out_res, mq[0].res);
            chk("m_out_rob", 32'(out_rob), 32'(mq[0].rob));
            chk("m_out_it", 32'(out_it), 32'(mq[0].it));
        end
        chk("b_out_valid", 32'(b_out_valid), 32'(bq.size() != 0));
        chk("b_count", 32'(b_count), 32'(bq.size()));
        chk("b_count_le3", 32'(b_count <= 2'd3 && bq.size() <= 3), 32'd1);
        if (bq.size() != 0) begin
            chk("b_out_pc", b_out_pc, bq[0].pc);
            chk("b_out_res", b_out_res, bq[0].res);
        end
    end

    // Handshake safety: no accept when full, no consume when empty.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(in_valid && in_ready && count == 2'd2))
                else $error("push accepted while full");
            assert (!(out_valid && out_ready && count == 2'd0))
                else $error("pop while empty");
            assert (!(b_in_valid && b_in_ready && b_count == 2'd3))
                else $error("push accepted while full (DEPTH=3)");
        end
    end

    ent_t got[$];
    always @(posedge clk) begin
        if (!reset && b_out_valid && b_out_ready)
            got.push_back('{b_out_it, b_out_pc, b_out_res, b_out_rob});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] rob);
        in_valid = v;
        in_pc    = pc;
        in_res   = pc ^ 32'hA5A5_0000;
        in_rob   = rob;
        in_it    = pc[4:2];
    endtask

    initial begin
        int idx;
        int budget;
        repeat (2) tick();
        reset = 1'b0;
        chk("post_reset_count", 32'(count), 32'd0);
        chk("post_reset_out_pc", out_pc, 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Streaming
        out_ready = 1;
        drive(1, 32'h100, 4'd1); tick();
        chk("stream_pc0", out_pc, 32'h100);
        chk("stream_cnt0", 32'(count), 32'd1);
        drive(1, 32'h104, 4'd2); tick();
        chk("stream_pc1", out_pc, 32'h104);
        chk("stream_rdy1", 32'(in_ready), 32'd1);
        drive(1, 32'h108, 4'd3); tick();
        chk("stream_pc2", out_pc, 32'h108);
        chk("stream_cnt2", 32'(count), 32'd1);
        drive(0, 32'h0, 4'd0); tick();
        chk("stream_drained", 32'(count), 32'd0);

        // Back-pressure and full with simultaneous push/pop
        out_ready = 0;
        drive(1, 32'h200, 4'd3); tick();
        drive(1, 32'h204, 4'd4); tick();
        chk("bp_full_cnt", 32'(count), 32'd2);
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        drive(1, 32'h208, 4'd5); tick();
        chk("bp_hold_cnt", 32'(count), 32'd2);
        chk("bp_hold_pc", out_pc, 32'h200);
        chk("bp_hold_rob", 32'(out_rob), 32'd3);
        out_ready = 1; tick();
        chk("full_pushpop_cnt", 32'(count), 32'd1);
        chk("bp_pc1", out_pc, 32'h204);
        chk("bp_rob1", 32'(out_rob), 32'd4);
        tick();
        chk("bp_pc2", out_pc, 32'h208);
        chk("bp_cnt2", 32'(count), 32'd1);
        drive(0, 32'h0, 4'd0); tick();
        chk("bp_drained", 32'(count), 32'd0);

        // Flush with a concurrent push
        out_ready = 0;
        drive(1, 32'h280, 4'd6); tick();
        drive(1, 32'h284, 4'd7); tick();
        chk("fl_pre_cnt", 32'(count), 32'd2);
        flush = 1; out_ready = 1;
        drive(1, 32'h300, 4'd8); tick();
        flush = 0;
        drive(0, 32'h0, 4'd0);
        chk("fl_cnt", 32'(count), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        chk("fl_no_300", 32'(out_pc != 32'h300), 32'd1);
        tick();
        chk("fl_no_300_later", 32'(out_pc != 32'h300), 32'd1);

        // Asynchronous reset with two entries held
        out_ready = 0;
        drive(1, 32'h400, 4'd9); tick();
        drive(1, 32'h404, 4'd10); tick();
        drive(0, 32'h0, 4'd0);
        chk("rst_pre_cnt", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnt", 32'(count), 32'd0);
        chk("async_rst_rdy", 32'(in_ready), 32'd1);
        chk("async_rst_pc", out_pc, 32'd0);
        chk("async_rst_res", out_res, 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1;
        drive(1, 32'h500, 4'd11); tick();
        chk("after_rst_pc", out_pc, 32'h500);
        chk("after_rst_cnt", 32'(count), 32'd1);
        drive(0, 32'h0, 4'd0); tick();

        // Wrap with DEPTH=3 under random consumer stalls
        idx = 0;
        budget = 0;
        while (idx < 7 && budget < 200) begin
            bit acc;
            b_in_valid  = 1;
            b_in_pc     = 32'h10 + 32'(idx);
            b_in_res    = 32'h11 + 32'(idx);
            b_in_rob    = 4'(idx);
            b_in_it     = 3'(idx);
            b_out_ready = ($urandom_range(0, 2) == 0);
            acc = b_in_ready;
            tick();
            if (acc) idx++;
            budget++;
        end
        chk("wrap_all_pushed", 32'(idx), 32'd7);
        b_in_valid  = 0;
        b_out_ready = 1;
        budget = 0;
        while (got.size() < 7 && budget < 50) begin
            tick();
            budget++;
        end
        chk("wrap_got_count", 32'(got.size()), 32'd7);
        for (int i = 0; i < got.size() && i < 7; i++) begin
            chk("wrap_pc", got[i].pc, 32'h10 + 32'(i));
            chk("wrap_res", got[i].res, 32'h11 + 32'(i));
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
